e_mdu: RTL and testbench

Execute-stage multiply/divide unit of the 5-stage MIPS pipeline. It runs mult/multu/div/divu as multi-cycle operations into private HI/LO registers, serves mfhi/mflo/mthi/mtlo, and drives the `start`/`busy` pair. The hazard unit consumes `start`/`busy` to stall any multiply/divide-class instruction in D while the unit is occupied. Operands arrive already forwarded from the E-stage A/B muxes.

---
 rtl/e_mdu.sv | 147 ++++++++++++++
 tb/tb_e_mdu.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle mult/div into private HI/LO, plus mfhi/mflo/mthi/mtlo.
// Optional MDU_MADD_EN adds madd/maddu/msub/msubu accumulate ops (MDOp 9-12).
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDOp,
    input  logic        Req,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDOut
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [3:0]       op_q, op_d;

    logic             launch_op, is_div_launch;
    logic [63:0]      prod_s, prod_u, res;
    logic             res_we;
    logic             sgn_a, sgn_b;
    logic [31:0]      mag_a, mag_b, uq, ur, quo, rem;

    // Launch decode on the live E-stage op
    always_comb begin
        is_div_launch = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
        launch_op     = (MDOp == OP_MULT) || (MDOp == OP_MULTU) || is_div_launch;
`ifdef MDU_MADD_EN
        launch_op     = launch_op || (MDOp == OP_MADD) || (MDOp == OP_MADDU)
                                  || (MDOp == OP_MSUB) || (MDOp == OP_MSUBU);
`endif
        start = launch_op & ~Req & ~busy_q;
    end

    // Result datapath from latched operands; signed divide goes through magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 with remainder 0 instead of overflowing.
    always_comb begin
        prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u = {32'd0, a_q} * {32'd0, b_q};
        sgn_a  = (op_q == OP_DIV) & a_q[31];
        sgn_b  = (op_q == OP_DIV) & b_q[31];
        mag_a  = sgn_a ? -a_q : a_q;
        mag_b  = sgn_b ? -b_q : b_q;
        uq     = mag_a / mag_b;
        ur     = mag_a % mag_b;
        quo    = (sgn_a ^ sgn_b) ? -uq : uq;
        rem    = sgn_a ? -ur : ur;
        res    = {hi_q, lo_q};
        res_we = 1'b0;
        case (op_q)
            OP_MULT:  begin res = prod_s;     res_we = 1'b1;          end
            OP_MULTU: begin res = prod_u;     res_we = 1'b1;          end
            OP_DIV,
            OP_DIVU:  begin res = {rem, quo}; res_we = (b_q != 32'd0); end
`ifdef MDU_MADD_EN
            OP_MADD:  begin res = {hi_q, lo_q} + prod_s; res_we = 1'b1; end
            OP_MADDU: begin res = {hi_q, lo_q} + prod_u; res_we = 1'b1; end
            OP_MSUB:  begin res = {hi_q, lo_q} - prod_s; res_we = 1'b1; end
            OP_MSUBU: begin res = {hi_q, lo_q} - prod_u; res_we = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Next state: completion, launch, or move-to-HI/LO
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                if (res_we) begin
                    hi_d = res[63:32];
                    lo_d = res[31:0];
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (start) begin
            busy_d = 1'b1;
            a_d    = A;
            b_d    = B;
            op_d   = MDOp;
            cnt_d  = is_div_launch ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (!Req) begin
            if (MDOp == OP_MTHI) hi_d = A;
            if (MDOp == OP_MTLO) lo_d = A;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy  = busy_q;
    assign HI    = hi_q;
    assign LO    = lo_q;
    assign MDOut = (MDOp == OP_MFHI) ? hi_q : (MDOp == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO queued at launch, popped when busy drops.
module tb_e_mdu;

    logic        clk;
    logic        reset_n;
    logic [31:0] A, B;
    logic [3:0]  MDOp;
    logic        Req;
    logic        start, busy;
    logic [31:0] HI, LO, MDOut;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [63:0] sb[$];

    e_mdu dut (
        .clk    (clk),
        .reset_n(reset_n),
        .A      (A),
        .B      (B),
        .MDOp   (MDOp),
        .Req    (Req),
        .start  (start),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .MDOut  (MDOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one op, optionally disturb inputs while busy, then pop and compare the result
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] eh,
                          input logic [31:0] el, input bit disturb);
        logic [63:0] e;
        int n;
        MDOp = op; A = a; B = b; Req = 1'b0;
        #1;
        chk({tag, "/start"}, 32'(start), 32'd1);
        sb.push_back({eh, el});
        step();
        MDOp = 4'd0; A = '0; B = '0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (disturb) begin
                A = 32'hDEADBEEF;
                case (n % 3)
                    0:       begin MDOp = 4'd3; Req = 1'b0; end
                    1:       begin MDOp = 4'd8; Req = 1'b1; end
                    default: begin MDOp = 4'd8; Req = 1'b0; end
                endcase
                #1;
                chk({tag, "/start_masked"}, 32'(start), 32'd0);
            end
            step();
        end
        MDOp = 4'd0; Req = 1'b0; A = '0;
        chk({tag, "/busy_cycles"}, 32'(n), 32'(cyc));
        if (sb.size() == 0) begin
            n_chk++;
            $error("FAIL %s/scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "/HI"}, HI, e[63:32]);
            chk({tag, "/LO"}, LO, e[31:0]);
        end
    endtask

    initial begin
        reset_n = 1'b0; A = '0; B = '0; MDOp = 4'd0; Req = 1'b0;
        #12;
        chk("rst/busy",  32'(busy),  32'd0);
        chk("rst/start", 32'(start), 32'd0);
        chk("rst/HI",    HI,         32'd0);
        chk("rst/LO",    LO,         32'd0);
        reset_n = 1'b1;
        step();

        // Back-to-back ops: each run_op launches in the cycle busy drops
        run_op("mult",     4'd1, 32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op("multu",    4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_op("div",      4'd3, 32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("divu0",    4'd4, 32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("div_ovf",  4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0);
        run_op("divu",     4'd4, 32'd100,      32'd7,        10, 32'd2,        32'd14,       1'b0);

        // mthi blocked by Req, then accepted
        MDOp = 4'd7; A = 32'h12345678; Req = 1'b1;
        step();
        chk("mthi_req/HI", HI, 32'd2);
        Req = 1'b0;
        step();
        chk("mthi/HI", HI, 32'h12345678);
        MDOp = 4'd5; #1;
        chk("mfhi/MDOut", MDOut, 32'h12345678);
        MDOp = 4'd6; #1;
        chk("mflo/MDOut", MDOut, 32'd14);
        MDOp = 4'd0; #1;
        chk("none/MDOut", MDOut, 32'd0);

        // Req suppresses a launch
        MDOp = 4'd1; A = 32'd3; B = 32'd4; Req = 1'b1; #1;
        chk("req_launch/start", 32'(start), 32'd0);
        step();
        chk("req_launch/busy", 32'(busy), 32'd0);
        MDOp = 4'd0; Req = 1'b0;

        // Req/mtlo/div during busy must not disturb the in-flight divide
        run_op("div_dist", 4'd3, 32'd20, 32'd6, 10, 32'd2, 32'd3, 1'b1);

        // Reset in busy cycle 4 discards the pending result
        MDOp = 4'd1; A = 32'd3; B = 32'd4; #1;
        chk("rstmid/start", 32'(start), 32'd1);
        step();
        MDOp = 4'd0;
        step(); step(); step();
        chk("rstmid/busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0; #1;
        chk("rstmid/busy", 32'(busy), 32'd0);
        chk("rstmid/HI",   HI,        32'd0);
        chk("rstmid/LO",   LO,        32'd0);
        #2 reset_n = 1'b1;
        step();
        chk("rstmid/busy_after", 32'(busy), 32'd0);
        chk("rstmid/HI_after",   HI,        32'd0);

        // Accumulate op from HI:LO = 0:0xFFFFFFFF
        MDOp = 4'd7; A = 32'd0; step();
        MDOp = 4'd8; A = 32'hFFFFFFFF; step();
        MDOp = 4'd0; A = '0;
        chk("preset/HI", HI, 32'd0);
        chk("preset/LO", LO, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        run_op("madd", 4'd9, 32'd1, 32'd1, 5, 32'd1, 32'd0, 1'b0);
`else
        MDOp = 4'd9; A = 32'd1; B = 32'd1; #1;
        chk("madd_off/start", 32'(start), 32'd0);
        step();
        MDOp = 4'd0;
        chk("madd_off/busy", 32'(busy), 32'd0);
        chk("madd_off/HI",   HI,        32'd0);
        chk("madd_off/LO",   LO,        32'hFFFFFFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
